// File: rtl/aes_block_loader_if.sv
// Word-in / block-out handshake bundle for aes_block_loader.
// The slave modport is the loader side and the master modport is the host/datapath side.
interface aes_block_loader_if #(
    parameter int BLOCK_W = 128,
    parameter int WORD_W  = 32
);
    localparam int WORDS = BLOCK_W / WORD_W;
    localparam int CNT_W = $clog2(WORDS) + 1;

    logic               in_valid;
    logic               in_ready;
    logic [WORD_W-1:0]  in_word;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_block;
    logic [CNT_W-1:0]   word_count;

    modport slave (
        input  in_valid,
        input  in_word,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_block,
        output word_count
    );

    modport master (
        output in_valid,
        output in_word,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_block,
        input  word_count
    );
endinterface

// File: rtl/aes_block_loader.sv
// Packs WORD_W-bit host words into one BLOCK_W-bit AES plaintext block (word 0 = MSW).
// Optional build macro AES_LOADER_BSWAP_EN byte-reverses each word before packing.
module aes_block_loader #(
    parameter int BLOCK_W = 128,
    parameter int WORD_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    aes_block_loader_if.slave bus
);
    localparam int WORDS = BLOCK_W / WORD_W;
    localparam int CNT_W = $clog2(WORDS) + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BLOCK_W-1:0] block_q, block_d;
    logic               valid_q, valid_d;

    logic               in_ready_s;
    logic               accept_s;
    logic               consume_s;
    logic [CNT_W-1:0]   slot_s;
    logic               write_s;
    logic [WORD_W-1:0]  word_s;

    function automatic logic [WORD_W-1:0] pack_word(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
`ifdef AES_LOADER_BSWAP_EN
        for (int b = 0; b < WORD_W / 8; b++) begin
            r[WORD_W-1-8*b -: 8] = w[8*b +: 8];
        end
`else
        r = w;
`endif
        return r;
    endfunction

    assign in_ready_s = ~reset & ~clear & ((state_q != ST_FULL) | bus.out_ready);
    assign accept_s   = bus.in_valid & in_ready_s;
    assign consume_s  = valid_q & bus.out_ready;
    assign word_s     = pack_word(bus.in_word);

    // Next-state, count and slot selection for the packer.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        valid_d = valid_q;
        slot_s  = '0;
        write_s = 1'b0;
        if (clear) begin
            state_d = ST_EMPTY;
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY, ST_FILLING: begin
                    if (accept_s) begin
                        write_s = 1'b1;
                        slot_s  = count_q;
                        count_d = count_q + CNT_W'(1);
                        if (count_q == CNT_W'(WORDS - 1)) begin
                            state_d = ST_FULL;
                            valid_d = 1'b1;
                        end else begin
                            state_d = ST_FILLING;
                            valid_d = 1'b0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_FULL: begin
                    if (consume_s && accept_s) begin
                        // Block leaves while the next block's first word lands in slot 0.
                        write_s = 1'b1;
                        slot_s  = '0;
                        count_d = CNT_W'(1);
                        if (WORDS == 1) begin
                            state_d = ST_FULL;
                            valid_d = 1'b1;
                        end else begin
                            state_d = ST_FILLING;
                            valid_d = 1'b0;
                        end
                    end else if (consume_s) begin
                        state_d = ST_EMPTY;
                        count_d = '0;
                        valid_d = 1'b0;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    count_d = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // Block datapath: only the selected slot is overwritten.
    always_comb begin
        block_d = block_q;
        for (int k = 0; k < WORDS; k++) begin
            if (write_s && (slot_s == CNT_W'(k))) begin
                block_d[BLOCK_W-1-k*WORD_W -: WORD_W] = word_s;
            end else begin
                block_d[BLOCK_W-1-k*WORD_W -: WORD_W] = block_q[BLOCK_W-1-k*WORD_W -: WORD_W];
            end
        end
    end

    // State, count, block and valid registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            count_q <= '0;
            block_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            block_q <= block_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = valid_q;
    assign bus.out_block  = block_q;
    assign bus.word_count = count_q;
endmodule

// File: tb/tb_aes_block_loader.sv
// Directed and randomized checks for aes_block_loader (4 x 32-bit words per block).
module tb_aes_block_loader;
    logic clock;
    logic reset;
    logic clear;

    int n_checks = 0;
    int n_pass   = 0;

    aes_block_loader_if #(.BLOCK_W(128), .WORD_W(32)) bus ();

    aes_block_loader #(.BLOCK_W(128), .WORD_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Word to drive so that the packed slot ends up holding w.
    function automatic logic [31:0] hw(input logic [31:0] w);
`ifdef AES_LOADER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Drive one word at posedge+1, wait (bounded) for ready, return at posedge+1 after acceptance.
    task automatic feed(input logic [31:0] w);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_word  = hw(w);
        #1;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 50) check_eq("feed_timeout", 128'(guard), 128'd0);
        @(posedge clock); #1;
    endtask

    logic [31:0]  v1 [4];
    logic [127:0] exp_q [$];
    logic [127:0] model_blk;
    logic [127:0] held;
    logic [31:0]  cur_word;
    int           nacc;
    int           blocks_done;
    int           cycles;
    logic         acc;
    logic         cons;

    initial begin
        v1[0] = 32'h00112233; v1[1] = 32'h44556677; v1[2] = 32'h8899AABB; v1[3] = 32'hCCDDEEFF;
        reset = 1'b1; clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_word = 32'h0; bus.out_ready = 1'b1;

        // Reset values
        #2;
        check_eq("rst_in_ready", 128'(bus.in_ready), 128'd0);
        check_eq("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check_eq("rst_out_block", bus.out_block, 128'd0);
        check_eq("rst_word_count", 128'(bus.word_count), 128'd0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        check_eq("post_rst_in_ready", 128'(bus.in_ready), 128'd1);

        // Back-to-back block with out_ready=1
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_word  = hw(v1[i]);
            @(posedge clock); #1;
            check_eq("b2b_count", 128'(bus.word_count), 128'(i + 1));
            check_eq("b2b_valid", 128'(bus.out_valid), (i == 3) ? 128'd1 : 128'd0);
        end
        bus.in_valid = 1'b0;
        check_eq("b2b_block", bus.out_block, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        @(posedge clock); #1;
        check_eq("b2b_valid_drop", 128'(bus.out_valid), 128'd0);
        check_eq("b2b_count_zero", 128'(bus.word_count), 128'd0);

        // Held block under back-pressure, then consume+accept in one cycle
        bus.out_ready = 1'b0;
        feed(32'hA0A1A2A3); feed(32'hB0B1B2B3); feed(32'hC0C1C2C3); feed(32'hD0D1D2D3);
        bus.in_word = hw(32'hE0E1E2E3);
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("hold_in_ready", 128'(bus.in_ready), 128'd0);
            check_eq("hold_block", bus.out_block, 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);
            check_eq("hold_valid", 128'(bus.out_valid), 128'd1);
            @(posedge clock); #1;
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("resume_in_ready", 128'(bus.in_ready), 128'd1);
        @(posedge clock); #1;
        check_eq("resume_count", 128'(bus.word_count), 128'd1);
        check_eq("resume_valid", 128'(bus.out_valid), 128'd0);
        feed(32'hF0F1F2F3); feed(32'h01020304); feed(32'h05060708);
        bus.in_valid = 1'b0;
        check_eq("resume_block", bus.out_block, 128'hE0E1E2E3_F0F1F2F3_01020304_05060708);
        @(posedge clock); #1;
        check_eq("resume_empty", 128'(bus.word_count), 128'd0);

        // Clear after two words drops partial and the word offered during clear
        feed(32'h11111111); feed(32'h22222222);
        check_eq("pre_clear_count", 128'(bus.word_count), 128'd2);
        clear = 1'b1; bus.in_word = hw(32'hDEADBEEF);
        #1;
        check_eq("clear_in_ready", 128'(bus.in_ready), 128'd0);
        @(posedge clock); #1;
        clear = 1'b0;
        check_eq("clear_count", 128'(bus.word_count), 128'd0);
        check_eq("clear_valid", 128'(bus.out_valid), 128'd0);
        feed(32'h0A0B0C0D); feed(32'h1A1B1C1D); feed(32'h2A2B2C2D); feed(32'h3A3B3C3D);
        bus.in_valid = 1'b0;
        check_eq("clear_block", bus.out_block, 128'h0A0B0C0D_1A1B1C1D_2A2B2C2D_3A3B3C3D);
        check_eq("clear_block_valid", 128'(bus.out_valid), 128'd1);
        @(posedge clock); #1;

        // Asynchronous reset mid-block
        feed(32'h55555555); feed(32'h66666666); feed(32'h77777777);
        bus.in_valid = 1'b0;
        check_eq("pre_rst_count", 128'(bus.word_count), 128'd3);
        #1 reset = 1'b1;
        #1;
        check_eq("arst_count", 128'(bus.word_count), 128'd0);
        check_eq("arst_valid", 128'(bus.out_valid), 128'd0);
        check_eq("arst_block", bus.out_block, 128'd0);
        check_eq("arst_in_ready", 128'(bus.in_ready), 128'd0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        feed(32'h89ABCDEF); feed(32'h01234567); feed(32'hFEDCBA98); feed(32'h76543210);
        bus.in_valid = 1'b0;
        check_eq("arst_fresh_block", bus.out_block, 128'h89ABCDEF_01234567_FEDCBA98_76543210);
        @(posedge clock); #1;

        // Raw word 0x33221100 driven directly (byte order depends on build)
        bus.in_valid = 1'b1; bus.in_word = 32'h33221100;
        @(posedge clock); #1;
        feed(32'h0); feed(32'h0); feed(32'h0);
        bus.in_valid = 1'b0;
`ifdef AES_LOADER_BSWAP_EN
        check_eq("bswap_word0", 128'(bus.out_block[127:96]), 128'h00112233);
`else
        check_eq("raw_word0", 128'(bus.out_block[127:96]), 128'h33221100);
`endif
        @(posedge clock); #1;

        // Randomized handshakes over 1000 blocks against a shift-packing model
        nacc = 0; blocks_done = 0; cycles = 0; model_blk = '0;
        cur_word = $urandom;
        while (blocks_done < 1000 && cycles < 60000) begin
            bus.in_valid  = (nacc < 4000) && ($urandom_range(0, 3) != 0);
            bus.in_word   = hw(cur_word);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc  = bus.in_valid & bus.in_ready;
            cons = bus.out_valid & bus.out_ready;
            if (cons) begin
                if (exp_q.size() == 0) begin
                    check_eq("rand_dup", bus.out_block, 128'hX);
                end else begin
                    held = exp_q.pop_front();
                    check_eq("rand_block", bus.out_block, held);
                end
                blocks_done++;
            end
            if (acc) begin
                model_blk = {model_blk[95:0], cur_word};
                nacc++;
                if (nacc % 4 == 0) exp_q.push_back(model_blk);
                cur_word = $urandom;
            end
            @(posedge clock); #1;
            cycles++;
        end
        bus.in_valid = 1'b0;
        check_eq("rand_blocks_done", 128'(blocks_done), 128'd1000);
        check_eq("rand_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/aes_block_loader.md
# aes_block_loader

Input-side stage of the AES encryption datapath. Collects a stream of narrow words from the host over a valid/ready handshake, packs them into one full plaintext block and presents it with its own valid/ready handshake. Drives the data input and load-enable of the 128-bit state register directly: block bus to `D`, `out_valid & out_ready` to `enable`. Holds one completed block while the packer is idle, and accepts the first word of the next block in the same cycle the held block is consumed.

## Interface
- `BLOCK_W`, 128, width of the assembled block; must be an integer multiple of `WORD_W`.
- `WORD_W`, 32, width of each input word.
- `WORDS` (localparam), `BLOCK_W/WORD_W`, words per block; 4 by default.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `clear`  in  1  synchronous flush; drops any partial and any held block.
- `in_valid`  in  1  `in_word` is valid this cycle.
- `in_ready`  out  1  loader accepts `in_word` this cycle.
- `in_word`  in  `WORD_W`  input word.
- `out_valid`  out  1  `out_block` holds a complete block.
- `out_ready`  in  1  downstream consumes `out_block` this cycle.
- `out_block`  out  `BLOCK_W`  assembled block; goes to the state-register `D`.
- `word_count`  out  `$clog2(WORDS)+1`  words currently held in the partial or full block, range 0..`WORDS`.

## Operation
- States:
  - EMPTY: count 0, `out_valid`=0.
  - FILLING: count 1..`WORDS`-1, `out_valid`=0.
  - FULL: count=`WORDS`, `out_valid`=1.
- Accept condition: `in_valid & in_ready`.
  - Word k of a block (k=0 first) is written to bits [`BLOCK_W`-1-k·`WORD_W` -: `WORD_W`]. Word 0 is the MSW, i.e. AES byte 0 at the top.
- Consume condition: `out_valid & out_ready`.
- `in_ready`: 1 in EMPTY/FILLING; in FULL equals `out_ready`; forced 0 while `clear`=1.
- Transitions:
  - EMPTY: accept → FILLING, count 1. With `WORDS`=1, goes straight to FULL.
  - FILLING: each accept increments count; the accept at count=`WORDS`-1 → FULL.
  - FULL: consume without accept → EMPTY, count 0.
  - FULL: consume with accept → FILLING, count 1, new word in the word-0 slot. Remaining slots are don't-care until written.
  - FULL: no consume → hold. `out_block` and `out_valid` stay stable.
- `clear`: takes priority over everything. Next state EMPTY, count 0, `out_valid`=0. `out_block` is not required to be zeroed. Any handshake in that cycle is ignored.
- `in_valid`=0 or `out_ready`=0 never loses data. Back-pressure is lossless.
- `out_block` is only meaningful while `out_valid`=1.

## Timing
- Reset values: `out_valid`=0, `out_block`=0, `word_count`=0, internal state EMPTY.
  - `in_ready`=0 while `reset` is asserted.
  - `in_ready`=1 from the first cycle after release.
- Latency: `out_valid` rises on the clock edge that accepts the last word, so it is visible the cycle after that accept. Sustained throughput is 1 word/cycle.
- `out_block` and `out_valid` are registered outputs.
  - `in_ready` is combinational from state, `out_ready` and `clear`.
  - No combinational path from `in_valid` or `in_word` to any output.
- Reset asserted mid-block or mid-handshake: everything returns to reset values asynchronously. No partial word survives.

## Configuration
- `AES_LOADER_BSWAP_EN` defined: every accepted `in_word` is byte-reversed before packing (bits [7:0] become the MS byte of the slot), for little-endian hosts. Requires `WORD_W` to be a multiple of 8.
- Not defined: words are packed unmodified.
- Handshake, timing and state behaviour are identical in both builds.

## Test plan
- Reset, then 4 back-to-back words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with `out_ready`=1 → `out_valid` for exactly one cycle with `out_block`=0x00112233_44556677_8899AABB_CCDDEEFF. `word_count` steps 1,2,3,4,0.
- Full block held with `out_ready`=0 for 10 cycles while `in_valid`=1 → `in_ready`=0 and `out_block` unchanged throughout. Raising `out_ready` consumes the block and accepts a word in the same cycle → `word_count`=1.
- 2 words accepted, then `clear` pulsed with `in_valid`=1 → `word_count`=0, `out_valid`=0, the word in the clear cycle is dropped. The next 4 words form a clean block.
- `reset` asserted asynchronously after 3 words → all outputs return to reset values before the next edge. After release, a fresh 4-word block assembles correctly.
- Randomized `in_valid`/`out_ready` over 1000 blocks → the output block sequence matches the packed input stream exactly; no loss and no duplication.
- With `AES_LOADER_BSWAP_EN` defined: input 0x33221100 as word 0 → bits [127:96] of `out_block` = 0x00112233.
